// File: rtl/nerv_arb_pkg.sv
// Shared types and constants for the nerv memory arbiter.
package nerv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RUN,
        ARB_REFETCH,
        ARB_EXT
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_FETCH,
        SRC_DATA,
        SRC_EXT
    } arb_src_t;

    localparam int unsigned EXT_MAX_WAIT_DEF = 8;

    // Width of the external wait counter; never narrower than one bit.
    function automatic int unsigned wait_ctr_w(input int unsigned max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/nerv_mem_arbiter.sv
// Single-port SRAM arbiter for nerv: instruction fetch, data port and an external master.
// Optional perf counters are enabled by defining NERV_ARB_PERF_EN.
module nerv_mem_arbiter
    import nerv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned EXT_MAX_WAIT = EXT_MAX_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [31:0]       core_imem_addr,
    output logic [31:0]       core_imem_data,
    input  logic              core_dmem_valid,
    input  logic [31:0]       core_dmem_addr,
    input  logic [3:0]        core_dmem_wstrb,
    input  logic [31:0]       core_dmem_wdata,
    output logic [31:0]       core_dmem_rdata,
    input  logic              core_trap,
    output logic              core_stall,

    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic [31:0]       ext_addr,
    input  logic [3:0]        ext_wstrb,
    input  logic [31:0]       ext_wdata,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,

    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef NERV_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_ext_cnt
`endif
);

    localparam int unsigned         WAIT_W   = wait_ctr_w(EXT_MAX_WAIT);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(EXT_MAX_WAIT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_src_t          r_prev_src;
    arb_src_t          w_prev_src_nxt;
    logic [31:0]       r_dhold;
    logic [WAIT_W-1:0] r_wait_ctr;
    logic              r_ext_rvalid;
    logic              w_ext_force;
    logic              w_unused;

    assign w_ext_force = ext_valid && ((r_wait_ctr == WAIT_MAX) || core_trap);

    assign mem_en          = 1'b1;
    assign core_imem_data  = mem_rdata;
    assign core_dmem_rdata = r_dhold;
    assign ext_rdata       = mem_rdata;
    assign ext_rvalid      = r_ext_rvalid;

    assign w_unused = ^{core_imem_addr[31:ADDR_W+2], core_imem_addr[1:0],
                        core_dmem_addr[31:ADDR_W+2], core_dmem_addr[1:0],
                        ext_addr[31:ADDR_W+2], ext_addr[1:0]};

    // Every non-granting cycle is an instruction fetch of the (possibly held) imem address.
    always_comb begin
        w_state_nxt    = r_state;
        w_prev_src_nxt = SRC_FETCH;
        core_stall     = 1'b0;
        ext_ready      = 1'b0;
        mem_addr       = core_imem_addr[ADDR_W+1:2];
        mem_wstrb      = '0;
        mem_wdata      = core_dmem_wdata;
        case (r_state)
            ARB_RUN: begin
                if (w_ext_force) begin
                    mem_addr       = ext_addr[ADDR_W+1:2];
                    mem_wstrb      = ext_wstrb;
                    mem_wdata      = ext_wdata;
                    ext_ready      = 1'b1;
                    core_stall     = 1'b1;
                    w_prev_src_nxt = SRC_EXT;
                    w_state_nxt    = ARB_EXT;
                end else if (core_dmem_valid) begin
                    mem_addr       = core_dmem_addr[ADDR_W+1:2];
                    mem_wstrb      = core_dmem_wstrb;
                    w_prev_src_nxt = SRC_DATA;
                    w_state_nxt    = ARB_REFETCH;
                end
            end
            ARB_REFETCH: begin
                core_stall  = 1'b1;
                w_state_nxt = ARB_RUN;
            end
            ARB_EXT: begin
                core_stall  = 1'b1;
                w_state_nxt = ARB_RUN;
            end
            default: begin
                w_state_nxt = ARB_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_RUN;
            r_prev_src   <= SRC_FETCH;
            r_dhold      <= '0;
            r_wait_ctr   <= '0;
            r_ext_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_src   <= w_prev_src_nxt;
            r_ext_rvalid <= ext_ready;
            if (r_state == ARB_REFETCH && r_prev_src == SRC_DATA) begin
                r_dhold <= mem_rdata;
            end
            // Saturates at WAIT_MAX so the force compare stays an equality.
            if (ext_ready) begin
                r_wait_ctr <= '0;
            end else if (ext_valid && r_wait_ctr != WAIT_MAX) begin
                r_wait_ctr <= r_wait_ctr + WAIT_W'(1);
            end
        end
    end

`ifdef NERV_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_ext   <= '0;
        end else begin
            if (core_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (ext_valid && ext_ready) begin
                r_perf_ext <= r_perf_ext + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_ext_cnt   = r_perf_ext;
`endif

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Self-checking bench for nerv_mem_arbiter: directed vector table, corner sequences, randomized traffic.
module tb_nerv_mem_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned MAXW  = 3;
    localparam int unsigned WORDS = 1 << AW;

    logic          clock;
    logic          reset;
    logic [31:0]   core_imem_addr;
    logic [31:0]   core_imem_data;
    logic          core_dmem_valid;
    logic [31:0]   core_dmem_addr;
    logic [3:0]    core_dmem_wstrb;
    logic [31:0]   core_dmem_wdata;
    logic [31:0]   core_dmem_rdata;
    logic          core_trap;
    logic          core_stall;
    logic          ext_valid;
    logic          ext_ready;
    logic [31:0]   ext_addr;
    logic [3:0]    ext_wstrb;
    logic [31:0]   ext_wdata;
    logic          ext_rvalid;
    logic [31:0]   ext_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef NERV_ARB_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_ext_cnt;
`endif

    nerv_mem_arbiter #(.ADDR_W(AW), .EXT_MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .core_imem_addr(core_imem_addr), .core_imem_data(core_imem_data),
        .core_dmem_valid(core_dmem_valid), .core_dmem_addr(core_dmem_addr),
        .core_dmem_wstrb(core_dmem_wstrb), .core_dmem_wdata(core_dmem_wdata),
        .core_dmem_rdata(core_dmem_rdata), .core_trap(core_trap), .core_stall(core_stall),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_addr(ext_addr),
        .ext_wstrb(ext_wstrb), .ext_wdata(ext_wdata), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef NERV_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_ext_cnt(perf_ext_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input int unsigned w);
        if (w == 32'h40) return 32'hDEAD_BEEF;
        if (w == 32'h8)  return 32'hAABB_CCDD;
        return 32'h1000_0000 + w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Synchronous single-port SRAM with one cycle read latency.
    logic [31:0] sram [WORDS];
    logic        sram_reload;
    always @(posedge clock) begin
        if (sram_reload) begin
            for (int i = 0; i < int'(WORDS); i++) sram[i] <= pat(i);
        end else if (mem_en) begin
            mem_rdata     <= sram[mem_addr];
            sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wstrb);
        end
    end

    logic [31:0] gold [WORDS];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        core_imem_addr  = '0;
        core_dmem_valid = 1'b0;
        core_dmem_addr  = '0;
        core_dmem_wstrb = '0;
        core_dmem_wdata = '0;
        core_trap       = 1'b0;
        ext_valid       = 1'b0;
        ext_addr        = '0;
        ext_wstrb       = '0;
        ext_wdata       = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0]   imem;
        logic          dv;
        logic [31:0]   daddr;
        logic [3:0]    wstrb;
        logic [31:0]   wdata;
        logic          e_stall;
        logic [AW-1:0] e_maddr;
        logic [3:0]    e_mwstrb;
        logic          ci;
        logic [31:0]   e_idata;
        logic          cd;
        logic [31:0]   e_drdata;
    } vec_t;
    vec_t vecs [13];

    task automatic run_random(input int ncyc, input logic trap_v);
        logic        stall, have_prev, bubble_exp, ld_pend, rv_exp, rv_rd, acc;
        logic [31:0] ld_val, rv_val, a;
        logic [AW-1:0] prev_w, dw, ew;
        int          waited, bound;
        bool_init: begin
            have_prev = 0; bubble_exp = 0; ld_pend = 0; rv_exp = 0; rv_rd = 0;
            ld_val = '0; rv_val = '0; prev_w = '0; waited = 0;
        end
        bound = trap_v ? 1 : int'(MAXW) + 1;
        core_trap = trap_v;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            stall = core_stall;
            acc   = 1'b0;
            if (bubble_exp) check("rnd_bubble_stall", {31'b0, stall}, 32'd1);
            bubble_exp = 1'b0;
            if (ld_pend && !stall) begin
                check("rnd_load_data", core_dmem_rdata, ld_val);
                ld_pend = 1'b0;
            end
            if (have_prev && !stall) check("rnd_fetch_data", core_imem_data, gold[prev_w]);
            check("rnd_ext_rvalid", {31'b0, ext_rvalid}, {31'b0, rv_exp});
            if (rv_exp && rv_rd) check("rnd_ext_rdata", ext_rdata, rv_val);
            rv_exp = 1'b0;
            if (!ext_valid) check("rnd_ready_idle", {31'b0, ext_ready}, 32'd0);
            if (core_dmem_valid && !stall) begin
                dw = core_dmem_addr[AW+1:2];
                if (core_dmem_wstrb == 4'h0) begin
                    ld_pend = 1'b1;
                    ld_val  = gold[dw];
                end else begin
                    gold[dw] = merge(gold[dw], core_dmem_wdata, core_dmem_wstrb);
                end
                bubble_exp = 1'b1;
            end
            if (ext_valid) begin
                if (ext_ready) begin
                    n_tests++;
                    if (waited > bound) begin
                        n_fail++;
                        $display("FAIL rnd_ext_wait: waited %0d cycles, allowed %0d", waited, bound);
                    end
                    ew     = ext_addr[AW+1:2];
                    rv_exp = 1'b1;
                    rv_rd  = (ext_wstrb == 4'h0);
                    rv_val = gold[ew];
                    if (!rv_rd) gold[ew] = merge(gold[ew], ext_wdata, ext_wstrb);
                    acc    = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                    if (waited > bound + 2) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rnd_ext_starved: waited %0d cycles, allowed %0d", waited, bound);
                        acc    = 1'b1;
                        waited = 0;
                    end
                end
            end
            prev_w    = core_imem_addr[AW+1:2];
            have_prev = 1'b1;
            @(posedge clock);
            #1;
            if (!stall) begin
                a = $urandom;
                a[AW+1:2] = AW'($urandom_range(0, 63));
                a[1:0] = 2'b00;
                core_imem_addr = a;
                if (i < ncyc - 40 && $urandom_range(0, 9) < 3) begin
                    a = $urandom;
                    a[AW+1:2] = AW'($urandom_range(0, 63));
                    a[1:0] = 2'b00;
                    core_dmem_valid = 1'b1;
                    core_dmem_addr  = a;
                    core_dmem_wstrb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                    core_dmem_wdata = $urandom;
                end else begin
                    core_dmem_valid = 1'b0;
                end
            end
            if (acc) ext_valid = 1'b0;
            if (!ext_valid && i < ncyc - 40 && $urandom_range(0, 9) < 3) begin
                a = $urandom;
                a[AW+1:2] = AW'($urandom_range(0, 63));
                a[1:0] = 2'b00;
                ext_valid = 1'b1;
                ext_addr  = a;
                ext_wstrb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                ext_wdata = $urandom;
                waited    = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ia;
        logic        granted, st;
        int          waited;

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h000, 4'h0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0004, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h001, 4'h0, 1'b1, 32'h1000_0000, 1'b0, 32'h0};
        vecs[2]  = '{32'h0000_0008, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h002, 4'h0, 1'b1, 32'h1000_0001, 1'b0, 32'h0};
        vecs[3]  = '{32'h0000_000C, 1'b1, 32'h100, 4'h0, 32'h0,         1'b0, 14'h040, 4'h0, 1'b1, 32'h1000_0002, 1'b1, 32'h0};
        vecs[4]  = '{32'h0000_0010, 1'b0, 32'h000, 4'h0, 32'h0,         1'b1, 14'h004, 4'h0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[5]  = '{32'h0000_0010, 1'b1, 32'h020, 4'h3, 32'h1234_5678, 1'b0, 14'h008, 4'h3, 1'b1, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h0000_0014, 1'b0, 32'h000, 4'h0, 32'h0,         1'b1, 14'h005, 4'h0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{32'h0000_0014, 1'b1, 32'h020, 4'h0, 32'h0,         1'b0, 14'h008, 4'h0, 1'b1, 32'h1000_0005, 1'b0, 32'h0};
        vecs[8]  = '{32'h0000_0018, 1'b0, 32'h000, 4'h0, 32'h0,         1'b1, 14'h006, 4'h0, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{32'h0000_0018, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h006, 4'h0, 1'b1, 32'h1000_0006, 1'b1, 32'hAABB_5678};
        vecs[10] = '{32'hFFFF_0004, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h001, 4'h0, 1'b1, 32'h1000_0006, 1'b0, 32'h0};
        vecs[11] = '{32'h0000_0000, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h000, 4'h0, 1'b1, 32'h1000_0001, 1'b0, 32'h0};
        vecs[12] = '{32'h0000_0004, 1'b0, 32'h000, 4'h0, 32'h0,         1'b0, 14'h001, 4'h0, 1'b1, 32'h1000_0000, 1'b0, 32'h0};

        reset = 1'b1;
        idle_inputs();
        sram_reload = 1'b1;
        @(posedge clock);
        #1 sram_reload = 1'b0;
        @(negedge clock);
        check("rst_stall",   {31'b0, core_stall}, 32'd0);
        check("rst_ready",   {31'b0, ext_ready},  32'd0);
        check("rst_rvalid",  {31'b0, ext_rvalid}, 32'd0);
        check("rst_dhold",   core_dmem_rdata,     32'd0);
        check("rst_mem_en",  {31'b0, mem_en},     32'd1);
        do_reset();

        // Fetch stream, load, partial store, reload and address wrap.
        for (int i = 0; i < 13; i++) begin
            core_imem_addr  = vecs[i].imem;
            core_dmem_valid = vecs[i].dv;
            core_dmem_addr  = vecs[i].daddr;
            core_dmem_wstrb = vecs[i].wstrb;
            core_dmem_wdata = vecs[i].wdata;
            @(negedge clock);
            check($sformatf("vec%0d_stall", i), {31'b0, core_stall}, {31'b0, vecs[i].e_stall});
            check($sformatf("vec%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
            check($sformatf("vec%0d_mwstrb", i), {28'b0, mem_wstrb}, {28'b0, vecs[i].e_mwstrb});
            check($sformatf("vec%0d_ready", i), {31'b0, ext_ready}, 32'd0);
            if (vecs[i].e_mwstrb != 4'h0) check($sformatf("vec%0d_mwdata", i), mem_wdata, vecs[i].wdata);
            if (vecs[i].ci) check($sformatf("vec%0d_idata", i), core_imem_data, vecs[i].e_idata);
            if (vecs[i].cd) check($sformatf("vec%0d_drdata", i), core_dmem_rdata, vecs[i].e_drdata);
            @(posedge clock);
            #1;
        end

        // External request forced ahead of continuous fetches after EXT_MAX_WAIT cycles.
        do_reset();
        ia = 32'h0;
        core_imem_addr = ia;
        ext_valid = 1'b1;
        ext_addr  = 32'h0000_0100;
        ext_wstrb = 4'h0;
        granted = 1'b0;
        waited  = 0;
        for (int k = 0; k < 12 && !granted; k++) begin
            @(negedge clock);
            st = core_stall;
            if (ext_ready) begin
                granted = 1'b1;
                check("ext_grant_stall", {31'b0, core_stall}, 32'd1);
                check("ext_grant_maddr", 32'(mem_addr), 32'h40);
                check("ext_wait_cycles", 32'(waited), 32'(MAXW));
            end else begin
                check("ext_wait_nostall", {31'b0, core_stall}, 32'd0);
                waited++;
            end
            @(posedge clock);
            #1;
            if (granted) ext_valid = 1'b0;
            if (!st) begin
                ia = ia + 32'd4;
                core_imem_addr = ia;
            end
        end
        check("ext_granted", {31'b0, granted}, 32'd1);
        @(negedge clock);
        check("ext_rvalid_pulse", {31'b0, ext_rvalid}, 32'd1);
        check("ext_rdata", ext_rdata, 32'hDEAD_BEEF);
        check("ext_ph_stall", {31'b0, core_stall}, 32'd1);
        check("ext_ph_refetch", 32'(mem_addr), 32'(ia[AW+1:2]));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("ext_after_rvalid", {31'b0, ext_rvalid}, 32'd0);
        check("ext_after_stall", {31'b0, core_stall}, 32'd0);
        check("ext_after_idata", core_imem_data, 32'h1000_0000 + {2'b00, ia[31:2]});

        // External force collides with a core load: ext first, load served after.
        do_reset();
        core_trap       = 1'b1;
        ext_valid       = 1'b1;
        ext_addr        = 32'h0000_0100;
        ext_wstrb       = 4'h0;
        core_imem_addr  = 32'h30;
        core_dmem_valid = 1'b1;
        core_dmem_addr  = 32'h20;
        core_dmem_wstrb = 4'h0;
        @(negedge clock);
        check("col_ready", {31'b0, ext_ready}, 32'd1);
        check("col_stall0", {31'b0, core_stall}, 32'd1);
        check("col_maddr0", 32'(mem_addr), 32'h40);
        @(posedge clock);
        #1;
        ext_valid = 1'b0;
        core_trap = 1'b0;
        @(negedge clock);
        check("col_rvalid", {31'b0, ext_rvalid}, 32'd1);
        check("col_rdata", ext_rdata, 32'hDEAD_BEEF);
        check("col_stall1", {31'b0, core_stall}, 32'd1);
        check("col_maddr1", 32'(mem_addr), 32'hC);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("col_stall2", {31'b0, core_stall}, 32'd0);
        check("col_maddr2", 32'(mem_addr), 32'h8);
        @(posedge clock);
        #1;
        core_imem_addr  = 32'h34;
        core_dmem_valid = 1'b0;
        @(negedge clock);
        check("col_stall3", {31'b0, core_stall}, 32'd1);
        check("col_maddr3", 32'(mem_addr), 32'hD);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("col_stall4", {31'b0, core_stall}, 32'd0);
        check("col_load", core_dmem_rdata, 32'hAABB_5678);
        check("col_idata", core_imem_data, 32'h1000_000D);

        // Reset asserted while in EXT drops the pending response at once.
        do_reset();
        core_trap      = 1'b1;
        ext_valid      = 1'b1;
        ext_addr       = 32'h104;
        core_imem_addr = 32'h40;
        @(negedge clock);
        check("rx_ready", {31'b0, ext_ready}, 32'd1);
        @(posedge clock);
        #1;
        check("rx_in_ext_rvalid", {31'b0, ext_rvalid}, 32'd1);
        reset     = 1'b1;
        ext_valid = 1'b0;
        core_trap = 1'b0;
        #1;
        check("rx_async_rvalid", {31'b0, ext_rvalid}, 32'd0);
        check("rx_async_stall", {31'b0, core_stall}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rx_first_stall", {31'b0, core_stall}, 32'd0);
        check("rx_first_maddr", 32'(mem_addr), 32'h10);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rx_idata", core_imem_data, 32'h1000_0010);
        check("rx_no_rvalid", {31'b0, ext_rvalid}, 32'd0);

        // Randomized traffic against the reference memory.
        reset = 1'b1;
        idle_inputs();
        sram_reload = 1'b1;
        for (int i = 0; i < int'(WORDS); i++) gold[i] = pat(i);
        @(posedge clock);
        #1 sram_reload = 1'b0;
        do_reset();
        run_random(2000, 1'b0);
        run_random(600, 1'b1);
        run_random(300, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
